// File: rtl/regfile_seq_pkg.sv
// rtl/regfile_seq_pkg.sv - shared types and helpers for the register-pair command sequencer
package regfile_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_LDLO   = 3'd1,
    OP_LDHI   = 3'd2,
    OP_LDPAIR = 3'd3,
    OP_RDPAIR = 3'd4,
    OP_STPAIR = 3'd5,
    OP_MOVE   = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    PAIR_BC = 3'd0,
    PAIR_DE = 3'd1,
    PAIR_HL = 3'd2,
    PAIR_WZ = 3'd3,
    PAIR_PC = 3'd4,
    PAIR_SP = 3'd5
  } pair_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PH1  = 2'd1,
    ST_PH2  = 2'd2
  } state_e;

  typedef struct packed {
    logic lreg_wr;
    logic rreg_wr;
    logic lreg_rd;
    logic rreg_rd;
    logic dreg_wr;
    logic dreg_rd;
  } strobe_t;

  localparam logic [2:0] PAIR_ILLEGAL_MIN = 3'd6;

  function automatic logic pair_legal(input logic [2:0] code);
    return code < PAIR_ILLEGAL_MIN;
  endfunction

  function automatic logic op_two_phase(input op_e op);
    return (op == OP_LDPAIR) || (op == OP_STPAIR) || (op == OP_MOVE);
  endfunction

  function automatic logic op_uses_src(input op_e op);
    return (op == OP_RDPAIR) || (op == OP_STPAIR) || (op == OP_MOVE);
  endfunction

  function automatic logic op_uses_dst(input op_e op);
    return (op == OP_LDLO) || (op == OP_LDHI) || (op == OP_LDPAIR) || (op == OP_MOVE);
  endfunction

endpackage

// File: rtl/regfile_seq_pairdec.sv
// rtl/regfile_seq_pairdec.sv - pair code plus enable to one-hot select {bc,de,hl,wz,pc,sp}
module regfile_seq_pairdec
  import regfile_seq_pkg::*;
(
  input  logic [2:0] pair_code,
  input  logic       en,
  output logic [5:0] sel
);

  // Bit 5 is BC down to bit 0 for SP; illegal codes select nothing.
  always_comb begin
    sel = '0;
    if (en && pair_legal(pair_code)) begin
      sel = 6'b100000 >> pair_code;
    end
  end

endmodule

// File: rtl/regfile_seq.sv
// rtl/regfile_seq.sv - register-pair command sequencer; REGFILE_SEQ_ERR_EN adds cmd_err
module regfile_seq
  import regfile_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [2:0] cmd_src,
  input  logic [2:0] cmd_dst,
  output logic       bc_rw,
  output logic       de_rw,
  output logic       hl_rw,
  output logic       wz_rw,
  output logic       pc_rw,
  output logic       sp_rw,
  output logic       lreg_wr,
  output logic       rreg_wr,
  output logic       lreg_rd,
  output logic       rreg_rd,
  output logic       dreg_wr,
  output logic       dreg_rd,
  output logic       busy,
`ifdef REGFILE_SEQ_ERR_EN
  output logic       cmd_err,
`endif
  output logic       done
);

  state_e     state, state_next;
  op_e        op_q;
  logic [2:0] src_q, dst_q;

  op_e        eff_op;
  logic [2:0] eff_src, eff_dst;
  logic [2:0] code_n;
  logic       active_n;
  strobe_t    strb_raw, strb_n, strb_q;
  logic [5:0] sel_n, sel_q;
  logic       done_n, done_q, ready_q, busy_q;

  logic handshake;
  assign handshake = (state == ST_IDLE) && cmd_valid && ready_q;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (handshake) state_next = ST_PH1;
      ST_PH1:  state_next = op_two_phase(op_q) ? ST_PH2 : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they can be registered
  // and still appear in the first cycle of that state.
  always_comb begin
    eff_op   = (state == ST_IDLE) ? op_e'(cmd_op) : op_q;
    eff_src  = (state == ST_IDLE) ? cmd_src : src_q;
    eff_dst  = (state == ST_IDLE) ? cmd_dst : dst_q;
    code_n   = eff_dst;
    active_n = 1'b0;
    strb_raw = '0;
    if (state_next == ST_PH1) begin
      case (eff_op)
        OP_LDLO:   begin active_n = 1'b1; strb_raw.lreg_wr = 1'b1; end
        OP_LDHI:   begin active_n = 1'b1; strb_raw.rreg_wr = 1'b1; end
        OP_LDPAIR: begin active_n = 1'b1; strb_raw.lreg_wr = 1'b1; end
        OP_RDPAIR: begin active_n = 1'b1; code_n = eff_src; strb_raw.dreg_rd = 1'b1; end
        OP_STPAIR: begin active_n = 1'b1; code_n = eff_src; strb_raw.lreg_rd = 1'b1; end
        OP_MOVE:   begin active_n = 1'b1; code_n = eff_src; strb_raw.dreg_rd = 1'b1; end
        default:   active_n = 1'b0;
      endcase
    end else if (state_next == ST_PH2) begin
      case (eff_op)
        OP_LDPAIR: begin active_n = 1'b1; strb_raw.rreg_wr = 1'b1; end
        OP_STPAIR: begin active_n = 1'b1; code_n = eff_src; strb_raw.rreg_rd = 1'b1; end
        OP_MOVE:   begin active_n = 1'b1; strb_raw.dreg_wr = 1'b1; end
        default:   active_n = 1'b0;
      endcase
    end
    strb_n = (active_n && pair_legal(code_n)) ? strb_raw : '0;
    done_n = ((state_next == ST_PH1) && !op_two_phase(eff_op)) || (state_next == ST_PH2);
  end

  regfile_seq_pairdec u_pairdec (
    .pair_code (code_n),
    .en        (active_n),
    .sel       (sel_n)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      op_q    <= OP_NOP;
      src_q   <= '0;
      dst_q   <= '0;
      sel_q   <= '0;
      strb_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_next;
      if (handshake) begin
        op_q  <= op_e'(cmd_op);
        src_q <= cmd_src;
        dst_q <= cmd_dst;
      end
      sel_q   <= sel_n;
      strb_q  <= strb_n;
      ready_q <= (state_next == ST_IDLE);
      busy_q  <= (state_next != ST_IDLE);
      done_q  <= done_n;
    end
  end

`ifdef REGFILE_SEQ_ERR_EN
  logic err_n, err_q;
  always_comb begin
    err_n = done_n && ((eff_op == OP_RSVD)
                       || (op_uses_src(eff_op) && !pair_legal(eff_src))
                       || (op_uses_dst(eff_op) && !pair_legal(eff_dst)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_n;
  end

  assign cmd_err = err_q;
`endif

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign {bc_rw, de_rw, hl_rw, wz_rw, pc_rw, sp_rw} = sel_q;
  assign lreg_wr   = strb_q.lreg_wr;
  assign rreg_wr   = strb_q.rreg_wr;
  assign lreg_rd   = strb_q.lreg_rd;
  assign rreg_rd   = strb_q.rreg_rd;
  assign dreg_wr   = strb_q.dreg_wr;
  assign dreg_rd   = strb_q.dreg_rd;

endmodule

// File: tb/tb_regfile_seq.sv
// tb/tb_regfile_seq.sv - directed self-checking bench for regfile_seq
module tb_regfile_seq;

  localparam logic [5:0] S_NONE = 6'b000000, S_BC = 6'b100000, S_DE = 6'b010000,
                         S_HL = 6'b001000, S_WZ = 6'b000100, S_PC = 6'b000010,
                         S_SP = 6'b000001;
  localparam logic [5:0] T_NONE = 6'b000000, T_LW = 6'b100000, T_RW = 6'b010000,
                         T_LR = 6'b001000, T_RR = 6'b000100, T_DW = 6'b000010,
                         T_DR = 6'b000001;
  localparam logic [2:0] C_NONE = 3'b000, C_RDY = 3'b100, C_BUSY = 3'b010, C_DONE = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0, cmd_src = 3'd0, cmd_dst = 3'd0;
  logic cmd_ready, bc_rw, de_rw, hl_rw, wz_rw, pc_rw, sp_rw;
  logic lreg_wr, rreg_wr, lreg_rd, rreg_rd, dreg_wr, dreg_rd, busy, done;
`ifdef REGFILE_SEQ_ERR_EN
  logic cmd_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [14:0] obs, exp_v;

  always #5 clk = ~clk;

  assign obs = {bc_rw, de_rw, hl_rw, wz_rw, pc_rw, sp_rw,
                lreg_wr, rreg_wr, lreg_rd, rreg_rd, dreg_wr, dreg_rd,
                cmd_ready, busy, done};

  regfile_seq dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .bc_rw     (bc_rw),
    .de_rw     (de_rw),
    .hl_rw     (hl_rw),
    .wz_rw     (wz_rw),
    .pc_rw     (pc_rw),
    .sp_rw     (sp_rw),
    .lreg_wr   (lreg_wr),
    .rreg_wr   (rreg_wr),
    .lreg_rd   (lreg_rd),
    .rreg_rd   (rreg_rd),
    .dreg_wr   (dreg_wr),
    .dreg_rd   (dreg_rd),
    .busy      (busy),
`ifdef REGFILE_SEQ_ERR_EN
    .cmd_err   (cmd_err),
`endif
    .done      (done)
  );

  task automatic issue(input logic [2:0] op, input logic [2:0] src, input logic [2:0] dst);
    cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (obs !== 15'd0) begin errors++; $display("FAIL reset_hold obs=%b exp=%b", obs, 15'd0); end
    @(negedge clk);
    checks++; if (obs !== 15'd0) begin errors++; $display("FAIL reset_edge obs=%b exp=%b", obs, 15'd0); end
    rst = 1'b1;
    #1;
    checks++; if (obs !== 15'd0) begin errors++; $display("FAIL reset_release obs=%b exp=%b", obs, 15'd0); end
    @(negedge clk);
    exp_v = {S_NONE, T_NONE, C_RDY};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL reset_first_edge obs=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_nop();
    for (int k = 0; k < 2; k++) begin
      issue((k == 0) ? 3'd0 : 3'd7, 3'd2, 3'd2);
      cmd_valid = 1'b0;
      exp_v = {S_NONE, T_NONE, C_BUSY | C_DONE};
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL nop_ph1[%0d] obs=%b exp=%b", k, obs, exp_v); end
`ifdef REGFILE_SEQ_ERR_EN
      checks++; if (cmd_err !== (k == 1)) begin errors++; $display("FAIL nop_err[%0d] obs=%b exp=%b", k, cmd_err, (k == 1)); end
`endif
      @(negedge clk);
      exp_v = {S_NONE, T_NONE, C_RDY};
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL nop_idle[%0d] obs=%b exp=%b", k, obs, exp_v); end
    end
  endtask

  task automatic test_ldpair();
    issue(3'd3, 3'd0, 3'd2);
    cmd_valid = 1'b0;
    exp_v = {S_HL, T_LW, C_BUSY};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL ldpair_ph1 obs=%b exp=%b", obs, exp_v); end
    @(negedge clk);
    exp_v = {S_HL, T_RW, C_BUSY | C_DONE};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL ldpair_ph2 obs=%b exp=%b", obs, exp_v); end
`ifdef REGFILE_SEQ_ERR_EN
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL ldpair_err obs=%b exp=0", cmd_err); end
`endif
    @(negedge clk);
    exp_v = {S_NONE, T_NONE, C_RDY};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL ldpair_idle obs=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_move();
    issue(3'd6, 3'd4, 3'd3);
    cmd_valid = 1'b0; cmd_op = 3'd1; cmd_src = 3'd0; cmd_dst = 3'd1;
    exp_v = {S_PC, T_DR, C_BUSY};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL move_ph1 obs=%b exp=%b", obs, exp_v); end
    @(negedge clk);
    exp_v = {S_WZ, T_DW, C_BUSY | C_DONE};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL move_ph2 obs=%b exp=%b", obs, exp_v); end
    @(negedge clk);
    exp_v = {S_NONE, T_NONE, C_RDY};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL move_idle obs=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_back_to_back();
    issue(3'd4, 3'd5, 3'd0);
    for (int k = 0; k < 3; k++) begin
      exp_v = {S_SP, T_DR, C_BUSY | C_DONE};
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL b2b_ph1[%0d] obs=%b exp=%b", k, obs, exp_v); end
      if (k == 2) cmd_valid = 1'b0;
      @(negedge clk);
      exp_v = {S_NONE, T_NONE, C_RDY};
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL b2b_idle[%0d] obs=%b exp=%b", k, obs, exp_v); end
      @(negedge clk);
    end
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL b2b_stop obs=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_illegal();
    issue(3'd1, 3'd0, 3'd7);
    cmd_valid = 1'b0;
    exp_v = {S_NONE, T_NONE, C_BUSY | C_DONE};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL ldlo7_ph1 obs=%b exp=%b", obs, exp_v); end
`ifdef REGFILE_SEQ_ERR_EN
    checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL ldlo7_err obs=%b exp=1", cmd_err); end
`endif
    @(negedge clk);
    issue(3'd5, 3'd6, 3'd0);
    cmd_valid = 1'b0;
    exp_v = {S_NONE, T_NONE, C_BUSY};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL stpair6_ph1 obs=%b exp=%b", obs, exp_v); end
    @(negedge clk);
    exp_v = {S_NONE, T_NONE, C_BUSY | C_DONE};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL stpair6_ph2 obs=%b exp=%b", obs, exp_v); end
`ifdef REGFILE_SEQ_ERR_EN
    checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL stpair6_err obs=%b exp=1", cmd_err); end
`endif
    @(negedge clk);
    exp_v = {S_NONE, T_NONE, C_RDY};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL stpair6_idle obs=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_reset_mid();
    issue(3'd5, 3'd0, 3'd0);
    cmd_valid = 1'b0;
    exp_v = {S_BC, T_LR, C_BUSY};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL rstmid_ph1 obs=%b exp=%b", obs, exp_v); end
    #2 rst = 1'b0;
    #1;
    checks++; if (obs !== 15'd0) begin errors++; $display("FAIL rstmid_async obs=%b exp=%b", obs, 15'd0); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (obs !== 15'd0) begin errors++; $display("FAIL rstmid_release obs=%b exp=%b", obs, 15'd0); end
    @(negedge clk);
    exp_v = {S_NONE, T_NONE, C_RDY};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL rstmid_no_ph2 obs=%b exp=%b", obs, exp_v); end
    issue(3'd4, 3'd1, 3'd0);
    cmd_valid = 1'b0;
    exp_v = {S_DE, T_DR, C_BUSY | C_DONE};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL rstmid_next obs=%b exp=%b", obs, exp_v); end
    @(negedge clk);
    exp_v = {S_NONE, T_NONE, C_RDY};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL rstmid_idle obs=%b exp=%b", obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_nop();
    test_ldpair();
    test_move();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
